board_io_core: RTL and testbench
================================

Name: board_io_core

Overview:
- Board-level I/O helper block sitting beside the VGA and 7-segment logic in the top level.
- Provides three independent functions:
  - a rotating LED pattern combined with the switch inputs;
  - a combinational 4:1 single-bit multiplexer;
  - a PS/2 keyboard receiver with frame checking and an 8-slot scan-code FIFO.

Parameters:
- LED_PERIOD, 5000000, clk cycles between LED pattern rotations (must be >= 2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  8  board switches.
- ledr  output  16  LED bank; [15:8] rotating pattern, [7:0] switch mirror.
- a  input  4  mux data inputs.
- s  input  2  mux select.
- y  output  1  mux output.
- ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous).
- ps2_data  input  1  raw PS/2 data from keyboard.
- nextdata_n  input  1  active-low pop request for the scan-code FIFO.
- kbd_data  output  8  scan code at FIFO head.
- kbd_ready  output  1  FIFO non-empty.
- kbd_overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.

Behaviour:
LED section:
- 8-bit pattern register.
  - Reset value 8'h01.
  - 32-bit cycle counter, reset to 0.
- Counter increments every cycle.
  - When the counter equals LED_PERIOD-1 it wraps to 0.
  - In that same cycle the pattern rotates left by one: new = {pat[6:0], pat[7]}.
- First rotation takes effect LED_PERIOD cycles after reset deasserts. Each later rotation follows every LED_PERIOD cycles.
- ledr[15:8] = pattern register.
- ledr[7:0] = sw, purely combinational, with no reset dependence.

Mux section:
- Purely combinational: y = a[s].
  - s=0 selects a[0], s=1 selects a[1], s=2 selects a[2], s=3 selects a[3].
- Reset has no effect.

PS/2 receiver:
- ps2_clk passes through a 3-flop synchronizer shift register, reset to 0.
- A sample strobe fires when the synchronized clock shows a falling edge: the oldest stage is 1 and the next stage is 0. Latency from the raw edge to the strobe is 2–3 clk cycles.
- A 4-bit bit counter runs 0..10 and an 11-bit frame buffer holds the bits; both reset to 0.
- On a strobe with count < 10:
  - buffer[count] <= ps2_data;
  - count increments.
- On a strobe with count == 10, the frame is checked using the current ps2_data as the stop bit:
  - valid when buffer[0]==0 (start), stop==1, and XOR of buffer[9:1] == 1 (odd parity over data plus parity bit);
  - a valid frame pushes buffer[8:1] (LSB-first data) into the FIFO;
  - count returns to 0 whether the frame is valid or not;
  - an invalid frame is discarded silently, with no flag.
- There is no inter-frame timeout; the counter only advances on strobes.

FIFO:
- 8×8 storage with 3-bit write and read pointers, both reset to 0.
- Usable capacity is 7 entries.
  - Full when w_ptr+1 == r_ptr (mod 8).
  - Empty when w_ptr == r_ptr.
- kbd_ready = (w_ptr != r_ptr).
- kbd_data = fifo[r_ptr], combinational. The value is don't-care when empty.
- Pop occurs in every cycle where kbd_ready==1 and nextdata_n==0, and advances r_ptr by 1. Holding nextdata_n low for N cycles pops up to N entries.
- Pop with the FIFO empty has no effect.
- Push when not full writes fifo[w_ptr] and advances w_ptr.
- Push when full drops the frame, leaves the pointers unchanged and sets kbd_overflow.
- Simultaneous push and pop in one cycle:
  - both pointers advance;
  - the full check uses the pre-cycle pointers, so a push into a full FIFO with a concurrent pop is dropped and flags overflow.
- kbd_overflow:
  - resets to 0;
  - set only by a dropped push;
  - cleared by any successful pop;
  - if a pop and an overflowing drop occur in the same cycle, set wins.
- Reset mid-frame clears the counter, pointers, overflow and synchronizer; the partial frame is lost. FIFO storage contents need not be reset.

Test Plan:
- LED_PERIOD=4, sw=8'hA5: hold rst 2 cycles, release.
  - ledr=16'h01A5 for the first 3 cycles;
  - 16'h02A5 after the 4th edge;
  - 16'h80A5 → 16'h01A5 on the 8-rotation wrap;
  - changing sw updates ledr[7:0] in the same cycle.
- Mux with a=4'b1010, sweep s=0..3 → y=0,1,0,1; with a=4'b0001 → y=1,0,0,0.
- Send PS/2 frame for 8'h1C (start 0, LSB-first data, parity 0, stop 1) with ps2_clk half-period ≥ 4 clk.
  - kbd_ready rises within 4 clk of the 11th falling edge;
  - kbd_data=8'h1C;
  - one cycle of nextdata_n=0 → kbd_ready=0.
- Send 8'h1C with the parity bit flipped, then with stop bit 0 → kbd_ready remains 0 and kbd_overflow stays 0.
- Send 8 valid frames 8'h01..8'h08 without popping.
  - First 7 are stored and the 8th is dropped, so kbd_overflow=1.
  - Successive pops read 01..07; kbd_overflow clears on the first pop.
- Assert rst after 5 bits of a frame, then send a full valid frame 8'hF0 → exactly one entry 8'hF0, no corruption.

Source files
------------

// File: rtl/board_io_core.sv
// -----------------------------------------------------------------------------
// board_io_core
//   Board-level I/O helper that sits beside the VGA and 7-segment logic.
//   It contains three independent functions:
//     * LED bank: an 8-bit one-hot pattern rotates left every LED_PERIOD clocks
//       and is shown on ledr[15:8]. The switches are mirrored on ledr[7:0].
//     * A combinational 4:1 single-bit multiplexer, y = a[s].
//     * A PS/2 keyboard receiver. It checks each 11-bit frame and queues
//       valid scan codes in an 8-slot FIFO, of which 7 slots are usable.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   sw[7:0]      board switches
//   ledr[15:8]   rotating pattern
//   ledr[7:0]    switch mirror
//   a[3:0]       mux data inputs
//   s[1:0]       mux select
//   y            mux output
//   ps2_clk      raw keyboard clock, asynchronous to clk
//   ps2_data     raw keyboard data
//   nextdata_n   active-low pop request; pops once per cycle while low
//   kbd_data     scan code at the FIFO head (don't-care when empty)
//   kbd_ready    FIFO is not empty
//   kbd_overflow sticky: a valid frame was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module board_io_core #(
  parameter int unsigned LED_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  output logic [15:0] ledr,
  input  logic [3:0]  a,
  input  logic [1:0]  s,
  output logic        y,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        nextdata_n,
  output logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        kbd_overflow
);

  // ---------------------------------------------------------------------------
  // LED section
  // ---------------------------------------------------------------------------
  localparam logic [31:0] LED_LAST = 32'(LED_PERIOD - 1);

  logic [31:0] led_cnt;
  logic [7:0]  led_pat;

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt <= '0;
      led_pat <= 8'h01;
    end else if (led_cnt == LED_LAST) begin
      led_cnt <= '0;
      led_pat <= {led_pat[6:0], led_pat[7]};
    end else begin
      led_cnt <= led_cnt + 32'd1;
    end
  end

  assign ledr = {led_pat, sw};

  // ---------------------------------------------------------------------------
  // Mux section
  // ---------------------------------------------------------------------------
  assign y = a[s];

  // ---------------------------------------------------------------------------
  // PS/2 receiver
  // ---------------------------------------------------------------------------
  logic [2:0]  ps2_sync;   // [0] newest, [2] oldest
  logic        ps2_strobe;
  logic [3:0]  bit_cnt;
  logic [10:0] frame_buf;
  logic        frame_done;
  logic        frame_ok;

  always_ff @(posedge clk) begin
    if (rst) ps2_sync <= '0;
    else     ps2_sync <= {ps2_sync[1:0], ps2_clk};
  end

  // Falling edge of the synchronized PS/2 clock.
  assign ps2_strobe = ps2_sync[2] & ~ps2_sync[1];

  // On the 11th strobe, the live ps2_data is the stop bit. Odd parity means
  // the XOR over the data and parity bits is 1.
  assign frame_done = ps2_strobe && (bit_cnt == 4'd10);
  assign frame_ok   = frame_done && !frame_buf[0] && ps2_data && (^frame_buf[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      frame_buf <= '0;
    end else if (ps2_strobe) begin
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
      end else begin
        frame_buf[bit_cnt] <= ps2_data;
        bit_cnt            <= bit_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code FIFO. One slot stays empty so that full and empty can be told
  // apart.
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_mem [8];
  logic [2:0] w_ptr;
  logic [2:0] r_ptr;
  logic       fifo_full;
  logic       do_pop;
  logic       do_push;
  logic       push_drop;

  assign fifo_full = (3'(w_ptr + 3'd1) == r_ptr);
  assign kbd_ready = (w_ptr != r_ptr);
  assign kbd_data  = fifo_mem[r_ptr];
  assign do_pop    = kbd_ready && !nextdata_n;
  assign do_push   = frame_ok && !fifo_full;   // full test uses pre-cycle pointers
  assign push_drop = frame_ok && fifo_full;

  // NOTE: storage is deliberately left without reset. The pointers define
  // which entries are valid, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[w_ptr] <= frame_buf[8:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      if (do_push) w_ptr <= w_ptr + 3'd1;
      if (do_pop)  r_ptr <= r_ptr + 3'd1;
      // A drop in the same cycle as a pop keeps the flag set.
      if (push_drop)   kbd_overflow <= 1'b1;
      else if (do_pop) kbd_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_board_io_core.sv
// -----------------------------------------------------------------------------
// tb_board_io_core
//   Directed testbench for board_io_core with LED_PERIOD = 4. It drives the
//   LED, mux, PS/2 framing and FIFO paths and compares every output against
//   values computed by hand. Outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_board_io_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic [15:0] ledr;
  logic [3:0]  a;
  logic [1:0]  s;
  logic        y;
  logic        ps2_clk;
  logic        ps2_data;
  logic        nextdata_n;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        kbd_overflow;

  int n_cmp = 0;
  int n_err = 0;

  board_io_core #(.LED_PERIOD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .ledr         (ledr),
    .a            (a),
    .s            (s),
    .y            (y),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .nextdata_n   (nextdata_n),
    .kbd_data     (kbd_data),
    .kbd_ready    (kbd_ready),
    .kbd_overflow (kbd_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Builds a PS/2 frame. Bit 0 is the start bit and bits 8:1 are the data,
  // LSB first. The parity bit makes the data-plus-parity XOR odd unless
  // flip_par is set.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip_par,
                                           input logic stop);
    logic par;
    par = ~(^d) ^ flip_par;
    return {stop, par, d, 1'b0};
  endfunction

  // Drives one PS/2 bit. Data is set while ps2_clk is high, then ps2_clk is
  // held low and high for 5 clk each.
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  exp_pat;
    logic        exp_y [4];
    logic [10:0] f;
    int          seen;

    rst        = 1'b1;
    sw         = 8'hA5;
    a          = 4'b0000;
    s          = 2'd0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;

    // ---------------- LED ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ledr", 32'(ledr), 32'h01A5);
    check("reset_ready", 32'(kbd_ready), 32'd0);
    check("reset_ovf", 32'(kbd_overflow), 32'd0);
    rst     = 1'b0;
    exp_pat = 8'h01;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k % 4 == 0) exp_pat = {exp_pat[6:0], exp_pat[7]};
      check($sformatf("led_k%0d", k), 32'(ledr), 32'({exp_pat, 8'hA5}));
    end
    check("led_wrap_back", 32'(exp_pat), 32'h01);
    sw = 8'h3C;
    #1 check("sw_mirror", 32'(ledr[7:0]), 32'h3C);

    // ---------------- Mux ----------------
    a = 4'b1010;
    exp_y = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1 check($sformatf("mux_1010_s%0d", i), 32'(y), 32'(exp_y[i]));
    end
    a = 4'b0001;
    exp_y = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1 check($sformatf("mux_0001_s%0d", i), 32'(y), 32'(exp_y[i]));
    end

    // ---------------- PS/2 single frame 1C ----------------
    f = mk_frame(8'h1C, 1'b0, 1'b1);
    check("frame_1c_par", 32'(f[9]), 32'd0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk) ps2_data = f[10];
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      @(negedge clk);
      if (kbd_ready) seen = 1;
    end
    check("ready_latency", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    check("data_1c", 32'(kbd_data), 32'h1C);
    pop_one();
    check("ready_after_pop", 32'(kbd_ready), 32'd0);

    // ---------------- Bad frames ----------------
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    check("bad_par_ready", 32'(kbd_ready), 32'd0);
    check("bad_par_ovf", 32'(kbd_overflow), 32'd0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    check("bad_stop_ready", 32'(kbd_ready), 32'd0);
    check("bad_stop_ovf", 32'(kbd_overflow), 32'd0);

    // ---------------- Fill and overflow ----------------
    for (int i = 1; i <= 8; i++) begin
      send_bits(mk_frame(8'(i), 1'b0, 1'b1), 11);
      if (i == 7) check("ovf_before_8th", 32'(kbd_overflow), 32'd0);
    end
    check("ovf_set", 32'(kbd_overflow), 32'd1);
    check("full_ready", 32'(kbd_ready), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("fifo_head_%0d", i), 32'(kbd_data), 32'(i));
      pop_one();
      if (i == 1) check("ovf_cleared", 32'(kbd_overflow), 32'd0);
    end
    check("drained_ready", 32'(kbd_ready), 32'd0);

    // ---------------- Reset mid-frame ----------------
    f = mk_frame(8'h1C, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11);
    check("rst_mid_ready", 32'(kbd_ready), 32'd1);
    check("rst_mid_data", 32'(kbd_data), 32'hF0);
    check("rst_mid_ovf", 32'(kbd_overflow), 32'd0);
    pop_one();
    check("rst_mid_single", 32'(kbd_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
